dmem_access_scheduler: RTL and testbench
========================================

Name: dmem_access_scheduler

Overview:
- Single-port access scheduler in front of the data memory.
- Merges committed stores, arriving from retire through an internal store queue, with speculative load requests from the load unit.
- Issues at most one memory operation per cycle and returns tagged load responses one cycle after issue.
- Enforces load-after-store ordering against queued stores and squashes load responses on pipeline flush.

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 32, byte address width
TAG_WIDTH, 4, load tag width (LSQ index)
SQ_DEPTH, 4, store queue entries (power of two, >=2)
STARVE_LIMIT, 3, consecutive load grants allowed while stores wait

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
st_valid  in  1  committed store request
st_ready  out  1  store accepted when st_valid&&st_ready
st_addr  in  ADDR_WIDTH  store byte address, word-aligned
st_data  in  DATA_WIDTH  store data
ld_valid  in  1  load request
ld_ready  out  1  load granted/issued when ld_valid&&ld_ready
ld_addr  in  ADDR_WIDTH  load byte address, word-aligned
ld_tag  in  TAG_WIDTH  load tag
ld_resp_valid  out  1  load data valid
ld_resp_tag  out  TAG_WIDTH  tag of returned load
ld_resp_data  out  DATA_WIDTH  load data
flush  in  1  squash speculative loads
sq_count  out  $clog2(SQ_DEPTH)+1  queued stores
mem_write_en  out  1  memory write strobe
waddr  out  ADDR_WIDTH  memory write address
wdata  out  DATA_WIDTH  memory write data
mem_rd_en  out  1  memory read strobe
raddr  out  ADDR_WIDTH  memory read address
rdata  in  DATA_WIDTH  memory read data, registered by memory
rdata_valid  in  1  high the cycle after mem_rd_en

Behaviour:
- Reset (synchronous): queue pointers and count = 0, starve counter = 0, in-flight flag = 0, ld_resp_valid = 0.
  - All queued stores are discarded; reset mid-operation drops any in-flight response.
  - During rst: st_ready = 0, ld_ready = 0, mem_write_en = 0, mem_rd_en = 0.
- Store queue: circular FIFO of {addr,data}.
  - st_ready = (sq_count < SQ_DEPTH), computed from registered count; no same-cycle pass-through when full.
  - Enqueue and dequeue in the same cycle leave the count unchanged.
  - Pointers wrap modulo SQ_DEPTH.
- Hazard: asserted when ld_valid and ld_addr[ADDR_WIDTH-1:2] equals the word address of any valid queue entry.
  - Stores enqueued in the same cycle are not checked.
  - Ordering against not-yet-accepted stores is the LSQ's responsibility.
- Arbitration (combinational, one grant per cycle, never read and write together):
  - grant_st = sq_nonempty && (!ld_valid || flush || hazard || sq_full || starve==STARVE_LIMIT).
  - grant_ld = ld_valid && !flush && !hazard && !grant_st.
  - ld_ready = grant_ld.
  - A load stalled by a hazard proceeds after the matching entries drain.
- Starve counter:
  - Increments on grant_ld while sq_nonempty, saturating at STARVE_LIMIT.
  - Clears on grant_st or when the queue is empty.
- Memory drive:
  - mem_write_en = grant_st, waddr/wdata = queue head; head dequeues at the same posedge.
  - mem_rd_en = grant_ld, raddr = ld_addr.
  - Addresses pass through unmodified.
- Load return:
  - On grant_ld, register tag and set the in-flight flag.
  - Next cycle: ld_resp_valid = rdata_valid && inflight && !flush, ld_resp_tag = registered tag, ld_resp_data = rdata.
  - Latency is exactly 1 cycle from grant.
  - Back-to-back loads are allowed: one per cycle.
- Flush:
  - Suppresses the response of a load issued the previous cycle.
  - Blocks new load grants in the flush cycle.
  - Never affects queued stores, which are architecturally committed.
- rdata_valid without an in-flight load is ignored.
- ld_valid requesters hold ld_addr/ld_tag stable until accepted.

Test Plan:
- Reset, then store A=0x10,D=0xDEADBEEF with no loads -> mem_write_en=1, waddr=0x10 the next cycle; sq_count returns 0.
- Enqueue 4 stores back-to-back while ld_valid is held to a non-matching address -> st_ready=0 at count 4; stores are forced out by sq_full and by the starve counter (store granted after every 3 load grants); no cycle has both strobes high.
- Store to 0x20 queued, load 0x20 tag 5 -> ld_ready=0 until the store writes; load issues the following cycle; ld_resp_tag=5, ld_resp_data = stored value one cycle later.
- Load 0x24 tag 3 granted, flush asserted the next cycle -> ld_resp_valid stays 0; queued stores still drain.
- Fill the queue, assert rst mid-drain -> sq_count=0, no further mem_write_en; st_ready=1 the cycle after rst deasserts.
- Loads issued every cycle, tags 1,2,3, empty queue -> responses appear on consecutive cycles with tags 1,2,3 in order.

Source files
------------

// File: rtl/dmem_access_scheduler.sv
// Single-port data-memory access scheduler.
// Committed stores wait in a circular store queue; speculative loads are
// issued directly when they do not alias a queued store. One memory
// operation per cycle, load data returned one cycle after issue.
module dmem_access_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int TAG_WIDTH    = 4,
  parameter int SQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [ADDR_WIDTH-1:0]        st_addr,
  input  logic [DATA_WIDTH-1:0]        st_data,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [ADDR_WIDTH-1:0]        ld_addr,
  input  logic [TAG_WIDTH-1:0]         ld_tag,
  output logic                         ld_resp_valid,
  output logic [TAG_WIDTH-1:0]         ld_resp_tag,
  output logic [DATA_WIDTH-1:0]        ld_resp_data,
  input  logic                         flush,
  output logic [$clog2(SQ_DEPTH):0]    sq_count,
  output logic                         mem_write_en,
  output logic [ADDR_WIDTH-1:0]        waddr,
  output logic [DATA_WIDTH-1:0]        wdata,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        raddr,
  input  logic [DATA_WIDTH-1:0]        rdata,
  input  logic                         rdata_valid
);

  localparam int PW = $clog2(SQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(SQ_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [ADDR_WIDTH-1:0] r_sq_addr [SQ_DEPTH];
  logic [DATA_WIDTH-1:0] r_sq_data [SQ_DEPTH];
  logic [SQ_DEPTH-1:0]   r_sq_vld;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [SW-1:0]         r_starve;
  logic                  r_inflight;
  logic [TAG_WIDTH-1:0]  r_tag;

  logic w_nonempty;
  logic w_full;
  logic w_hazard;
  logic w_grant_st;
  logic w_grant_ld;
  logic w_enq;

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == DEPTH_C);

  // Load hazard: requested word matches any store still waiting in the queue
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (r_sq_vld[i] && (r_sq_addr[i][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]))
        w_hazard = 1'b1;
    end
    if (!ld_valid)
      w_hazard = 1'b0;
  end

  // Stores win when no load can go, on flush, when full or after a load streak
  assign w_grant_st = !rst && w_nonempty &&
                      (!ld_valid || flush || w_hazard || w_full || (r_starve == STARVE_MAX));
  assign w_grant_ld = !rst && ld_valid && !flush && !w_hazard && !w_grant_st;

  assign st_ready = !rst && (r_count < DEPTH_C);
  assign w_enq    = st_valid && st_ready;
  assign ld_ready = w_grant_ld;
  assign sq_count = r_count;

  assign mem_write_en = w_grant_st;
  assign waddr        = r_sq_addr[r_head];
  assign wdata        = r_sq_data[r_head];
  assign mem_rd_en    = w_grant_ld;
  assign raddr        = ld_addr;

  assign ld_resp_valid = !rst && rdata_valid && r_inflight && !flush;
  assign ld_resp_tag   = r_tag;
  assign ld_resp_data  = rdata;

  // Queue control: pointers, occupancy and per-entry valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_sq_vld <= '0;
    end else begin
      if (w_enq) begin
        r_tail           <= r_tail + PW'(1);
        r_sq_vld[r_tail] <= 1'b1;
      end
      if (w_grant_st) begin
        r_head           <= r_head + PW'(1);
        r_sq_vld[r_head] <= 1'b0;
      end
      case ({w_enq, w_grant_st})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue payload storage, written at the tail on enqueue
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_sq_addr[r_tail] <= st_addr;
      r_sq_data[r_tail] <= st_data;
    end
  end

  // Count load grants taken while stores are waiting, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst || w_grant_st || !w_nonempty)
      r_starve <= '0;
    else if (w_grant_ld && (r_starve != STARVE_MAX))
      r_starve <= r_starve + SW'(1);
  end

  // Track the load issued this cycle so its data can be tagged next cycle
  always_ff @(posedge clk) begin
    if (rst)
      r_inflight <= 1'b0;
    else
      r_inflight <= w_grant_ld;
  end

  // Capture the tag of the issuing load
  always_ff @(posedge clk) begin
    if (w_grant_ld)
      r_tag <= ld_tag;
  end

endmodule

// File: tb/tb_dmem_access_scheduler.sv
// Bench for dmem_access_scheduler: memory model, queue-based reference
// model checked every cycle, and directed scenarios with literal values.
module tb_dmem_access_scheduler;

  localparam int SL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = '0;
  logic [3:0]  ld_tag = '0;
  logic        ld_resp_valid;
  logic [3:0]  ld_resp_tag;
  logic [31:0] ld_resp_data;
  logic        flush = 1'b0;
  logic [2:0]  sq_count;
  logic        mem_write_en;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        mem_rd_en;
  logic [31:0] raddr;
  logic [31:0] rdata = '0;
  logic        rdata_valid = 1'b0;

  always #5 clk = ~clk;

  dmem_access_scheduler dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_tag(ld_tag),
    .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag), .ld_resp_data(ld_resp_data),
    .flush(flush), .sq_count(sq_count),
    .mem_write_en(mem_write_en), .waddr(waddr), .wdata(wdata),
    .mem_rd_en(mem_rd_en), .raddr(raddr), .rdata(rdata), .rdata_valid(rdata_valid)
  );

  // Data memory: registered read, one-cycle latency
  bit [31:0] env_mem [256];
  always @(posedge clk) begin
    if (mem_write_en) env_mem[waddr[9:2]] <= wdata;
    rdata_valid <= mem_rd_en;
    rdata       <= env_mem[raddr[9:2]];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { logic [31:0] a; logic [31:0] d; } st_t;
  st_t       q[$];
  bit [31:0] mmem [256];
  int        starve = 0;
  bit        m_inflight = 1'b0;
  logic [3:0]  m_tag;
  logic [31:0] m_data;
  bit        chk_en = 1'b0;
  bit        e_ne, e_full, e_haz, e_gst, e_gld, e_sr, e_rv;

  always @(negedge clk) begin
    if (chk_en) begin
      e_ne   = (q.size() != 0);
      e_full = (q.size() == 4);
      e_haz  = 1'b0;
      foreach (q[i]) if (ld_valid && q[i].a[31:2] == ld_addr[31:2]) e_haz = 1'b1;
      e_gst = !rst && e_ne && (!ld_valid || flush || e_haz || e_full || starve == SL);
      e_gld = !rst && ld_valid && !flush && !e_haz && !e_gst;
      e_sr  = !rst && (q.size() < 4);
      e_rv  = !rst && m_inflight && !flush;

      chk("st_ready", 32'(st_ready), 32'(e_sr));
      chk("ld_ready", 32'(ld_ready), 32'(e_gld));
      chk("mem_write_en", 32'(mem_write_en), 32'(e_gst));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(e_gld));
      chk("sq_count", 32'(sq_count), 32'(q.size()));
      chk("one_strobe", 32'(mem_write_en & mem_rd_en), 32'd0);
      if (e_gst) begin
        chk("waddr", waddr, q[0].a);
        chk("wdata", wdata, q[0].d);
      end
      if (e_gld) chk("raddr", raddr, ld_addr);
      chk("ld_resp_valid", 32'(ld_resp_valid), 32'(e_rv));
      if (e_rv) begin
        chk("ld_resp_tag", 32'(ld_resp_tag), 32'(m_tag));
        chk("ld_resp_data", ld_resp_data, m_data);
      end

      if (rst) begin
        q.delete();
        starve     = 0;
        m_inflight = 1'b0;
      end else begin
        if (e_gst) begin
          mmem[q[0].a[9:2]] = q[0].d;
          void'(q.pop_front());
        end
        if (st_valid && e_sr) q.push_back('{st_addr, st_data});
        if (e_gst || !e_ne) starve = 0;
        else if (e_gld && starve < SL) starve++;
        m_inflight = e_gld;
        if (e_gld) begin
          m_tag  = ld_tag;
          m_data = mmem[ld_addr[9:2]];
        end
      end
    end
  end

  // Present a store until accepted; called and returns at posedge+1
  task automatic send_store(input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    st_valid = 1'b1; st_addr = a; st_data = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (st_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("store_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_sq_count", 32'(sq_count), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd0);
    chk("rst_resp_valid", 32'(ld_resp_valid), 32'd0);
    step();
    rst = 1'b0;

    // Single store, no loads
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_st_ready", 32'(st_ready), 32'd1);
    chk("t1_no_write_yet", 32'(mem_write_en), 32'd0);
    step();
    st_valid = 1'b0;
    @(negedge clk);
    chk("t1_write_en", 32'(mem_write_en), 32'd1);
    chk("t1_waddr", waddr, 32'h10);
    chk("t1_wdata", wdata, 32'hDEADBEEF);
    chk("t1_count1", 32'(sq_count), 32'd1);
    step();
    @(negedge clk);
    chk("t1_count0", 32'(sq_count), 32'd0);
    step();

    // Fill the queue under a continuous non-aliasing load stream
    ld_valid = 1'b1; ld_addr = 32'h100; ld_tag = 4'd0;
    for (int i = 0; i < 4; i++) send_store(32'h40 + 32'(4 * i), 32'hA0000000 + 32'(i));
    @(negedge clk);
    chk("t2_count4", 32'(sq_count), 32'd4);
    chk("t2_st_ready0", 32'(st_ready), 32'd0);
    chk("t2_write_en", 32'(mem_write_en), 32'd1);
    chk("t2_waddr", waddr, 32'h40);
    chk("t2_ld_ready0", 32'(ld_ready), 32'd0);
    repeat (12) step();
    ld_valid = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("t2_drained", 32'(sq_count), 32'd0);
    step();

    // Load aliasing a queued store waits for the write
    send_store(32'h20, 32'hCAFEF00D);
    ld_valid = 1'b1; ld_addr = 32'h20; ld_tag = 4'd5;
    @(negedge clk);
    chk("t3_ld_stalled", 32'(ld_ready), 32'd0);
    chk("t3_store_first", 32'(mem_write_en), 32'd1);
    chk("t3_waddr", waddr, 32'h20);
    step();
    @(negedge clk);
    chk("t3_ld_go", 32'(ld_ready), 32'd1);
    chk("t3_raddr", raddr, 32'h20);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    chk("t3_resp_valid", 32'(ld_resp_valid), 32'd1);
    chk("t3_resp_tag", 32'(ld_resp_tag), 32'd5);
    chk("t3_resp_data", ld_resp_data, 32'hCAFEF00D);
    step();

    // Flush squashes the response; queued store still drains
    send_store(32'h50, 32'h11111111);
    ld_valid = 1'b1; ld_addr = 32'h24; ld_tag = 4'd3;
    @(negedge clk);
    chk("t4_ld_go", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("t4_resp_squashed", 32'(ld_resp_valid), 32'd0);
    chk("t4_write_en", 32'(mem_write_en), 32'd1);
    chk("t4_waddr", waddr, 32'h50);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t4_drained", 32'(sq_count), 32'd0);
    step();

    // Reset in the middle of draining a full queue
    ld_valid = 1'b1; ld_addr = 32'h200; ld_tag = 4'd7;
    for (int i = 0; i < 4; i++) send_store(32'h60 + 32'(4 * i), 32'hB0000000 + 32'(i));
    @(negedge clk);
    chk("t5_count4", 32'(sq_count), 32'd4);
    step();
    rst = 1'b1; ld_valid = 1'b0;
    @(negedge clk);
    chk("t5_rst_no_write", 32'(mem_write_en), 32'd0);
    chk("t5_rst_st_ready", 32'(st_ready), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_count0", 32'(sq_count), 32'd0);
    chk("t5_st_ready1", 32'(st_ready), 32'd1);
    chk("t5_no_write", 32'(mem_write_en), 32'd0);
    step();

    // Back-to-back loads, empty queue
    ld_valid = 1'b1; ld_addr = 32'h10; ld_tag = 4'd1;
    @(negedge clk);
    chk("t6_ld1_go", 32'(ld_ready), 32'd1);
    step();
    ld_addr = 32'h40; ld_tag = 4'd2;
    @(negedge clk);
    chk("t6_resp1_valid", 32'(ld_resp_valid), 32'd1);
    chk("t6_resp1_tag", 32'(ld_resp_tag), 32'd1);
    chk("t6_resp1_data", ld_resp_data, 32'hDEADBEEF);
    step();
    ld_addr = 32'h44; ld_tag = 4'd3;
    @(negedge clk);
    chk("t6_resp2_tag", 32'(ld_resp_tag), 32'd2);
    chk("t6_resp2_data", ld_resp_data, 32'hA0000000);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    chk("t6_resp3_valid", 32'(ld_resp_valid), 32'd1);
    chk("t6_resp3_tag", 32'(ld_resp_tag), 32'd3);
    chk("t6_resp3_data", ld_resp_data, 32'hA0000001);
    step();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
